// File: rtl/xif_mem_pkg.sv
// Shared types for the XIF memory responder: FSM states, access-size codes and the result record.
package xif_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS_REQ,
    BUS_WAIT,
    RESULT
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  // Widest instruction id the result record can carry; narrower ids are zero-padded.
  localparam int unsigned XIF_ID_MAX = 32;

  typedef struct packed {
    logic [XIF_ID_MAX-1:0] id;
    logic [31:0]           rdata;
    logic                  err;
  } xif_mem_result_t;

endpackage

// File: rtl/xif_mem_lane_align.sv
// Combinational lane logic: load byte enables, right-aligned/zero-extended read data,
// and the natural-alignment flag for half/word accesses.
module xif_mem_lane_align
  import xif_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [3:0]  mem_be,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  data_be,
  output logic [31:0] rdata_aligned,
  output logic        misaligned
);

  logic [31:0] rdata_shifted;
  logic [3:0]  lane_keep;

  assign rdata_shifted = bus_rdata >> {addr_lo, 3'b000};

  always_comb begin
    lane_keep = 4'b1111;
    case (size)
      SIZE_BYTE: lane_keep = 4'b0001;
      SIZE_HALF: lane_keep = 4'b0011;
      default:   lane_keep = 4'b1111;
    endcase
  end

  always_comb begin
    data_be = 4'b1111;
    if (we) begin
      data_be = mem_be;
    end else if (size == SIZE_BYTE || size == SIZE_HALF) begin
      data_be = lane_keep << addr_lo;
    end
  end

  assign misaligned = ((size == SIZE_HALF) && addr_lo[0]) ||
                      ((size == SIZE_WORD) && (addr_lo != 2'b00));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rdata_aligned[8*gi +: 8] = rdata_shifted[8*gi +: 8] & {8{lane_keep[gi]}};
    end
  endgenerate

endmodule

// File: rtl/xif_mem_responder.sv
// XIF memory-channel responder: one load/store at a time onto the OBI data port.
// Optional macro XIF_MEM_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module xif_mem_responder
  import xif_mem_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [ID_WIDTH-1:0]   mem_id_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic [3:0]            mem_be_i,
  input  logic [31:0]           mem_wdata_i,
  output logic                  mem_result_valid_o,
  output logic [ID_WIDTH-1:0]   mem_result_id_o,
  output logic [31:0]           mem_result_rdata_o,
  output logic                  mem_result_err_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  input  logic                  data_err_i
);

  state_e                state_reg, state_next;
  logic [ID_WIDTH-1:0]   id_reg, id_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  we_reg, we_next;
  logic [1:0]            size_reg, size_next;
  logic [3:0]            be_reg, be_next;
  logic [31:0]           wdata_reg, wdata_next;
  xif_mem_result_t       result_reg, result_next;

  logic        is_idle;
  logic [1:0]  lane_size;
  logic [1:0]  lane_addr;
  logic        lane_we;
  logic [3:0]  lane_be;
  logic [31:0] lane_rdata;
  logic        misaligned;
  logic        reject;

  assign is_idle = (state_reg == IDLE);

  // One lane aligner serves both phases: incoming request in IDLE, held request afterwards.
  assign lane_size = is_idle ? mem_size_i      : size_reg;
  assign lane_addr = is_idle ? mem_addr_i[1:0] : addr_reg[1:0];
  assign lane_we   = is_idle ? mem_we_i        : we_reg;

  xif_mem_lane_align u_lane_align (
    .size          (lane_size),
    .addr_lo       (lane_addr),
    .we            (lane_we),
    .mem_be        (mem_be_i),
    .bus_rdata     (data_rdata_i),
    .data_be       (lane_be),
    .rdata_aligned (lane_rdata),
    .misaligned    (misaligned)
  );

`ifdef XIF_MEM_MISALIGN_CHECK_EN
  assign reject = (mem_size_i == SIZE_RSVD) || misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign reject = (mem_size_i == SIZE_RSVD);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      id_reg     <= '0;
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      size_reg   <= 2'b00;
      be_reg     <= 4'b0000;
      wdata_reg  <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      id_reg     <= id_next;
      addr_reg   <= addr_next;
      we_reg     <= we_next;
      size_reg   <= size_next;
      be_reg     <= be_next;
      wdata_reg  <= wdata_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    id_next     = id_reg;
    addr_next   = addr_reg;
    we_next     = we_reg;
    size_next   = size_reg;
    be_next     = be_reg;
    wdata_next  = wdata_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (mem_valid_i) begin
          id_next    = mem_id_i;
          addr_next  = mem_addr_i;
          we_next    = mem_we_i;
          size_next  = mem_size_i;
          be_next    = lane_be;
          wdata_next = mem_wdata_i;
          if (reject) begin
            result_next.id    = XIF_ID_MAX'(mem_id_i);
            result_next.rdata = '0;
            result_next.err   = 1'b1;
            state_next        = RESULT;
          end else begin
            state_next = BUS_REQ;
          end
        end
      end
      BUS_REQ: begin
        if (data_gnt_i) state_next = BUS_WAIT;
      end
      BUS_WAIT: begin
        if (data_rvalid_i) begin
          result_next.id    = XIF_ID_MAX'(id_reg);
          result_next.err   = data_err_i;
          result_next.rdata = (we_reg || data_err_i) ? 32'h0 : lane_rdata;
          state_next        = RESULT;
        end
      end
      RESULT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_ready_o        = is_idle;
  assign mem_result_valid_o = (state_reg == RESULT);
  assign mem_result_id_o    = result_reg.id[ID_WIDTH-1:0];
  assign mem_result_rdata_o = result_reg.rdata;
  assign mem_result_err_o   = result_reg.err;

  // Ids narrower than the record leave upper bits at zero.
  logic unused_id_bits;
  assign unused_id_bits = ^result_reg.id;

  assign data_req_o   = (state_reg == BUS_REQ);
  assign data_addr_o  = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
  assign data_we_o    = we_reg;
  assign data_be_o    = be_reg;
  assign data_wdata_o = wdata_reg;

endmodule

// File: tb/tb_xif_mem_responder.sv
// Self-checking bench for xif_mem_responder: vector table with a bus model plus a result scoreboard.
module tb_xif_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [3:0]  mem_id_i;
  logic [31:0] mem_addr_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_wdata_i;
  logic        mem_result_valid_o;
  logic [3:0]  mem_result_id_o;
  logic [31:0] mem_result_rdata_o;
  logic        mem_result_err_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  always #5 clk_i = ~clk_i;

  xif_mem_responder #(.ID_WIDTH(4), .ADDR_WIDTH(32)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .mem_valid_i        (mem_valid_i),
    .mem_ready_o        (mem_ready_o),
    .mem_id_i           (mem_id_i),
    .mem_addr_i         (mem_addr_i),
    .mem_we_i           (mem_we_i),
    .mem_size_i         (mem_size_i),
    .mem_be_i           (mem_be_i),
    .mem_wdata_i        (mem_wdata_i),
    .mem_result_valid_o (mem_result_valid_o),
    .mem_result_id_o    (mem_result_id_o),
    .mem_result_rdata_o (mem_result_rdata_o),
    .mem_result_err_o   (mem_result_err_o),
    .data_req_o         (data_req_o),
    .data_gnt_i         (data_gnt_i),
    .data_addr_o        (data_addr_o),
    .data_we_o          (data_we_o),
    .data_be_o          (data_be_o),
    .data_wdata_o       (data_wdata_o),
    .data_rvalid_i      (data_rvalid_i),
    .data_rdata_i       (data_rdata_i),
    .data_err_i         (data_err_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    logic        bus_err;
    int          gnt_wait;
    logic        reject;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (mem_result_valid_o) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got id=%0d rdata=0x%08h err=%0b expected no result",
                 mem_result_id_o, mem_result_rdata_o, mem_result_err_o);
      end else begin
        e = exp_q.pop_front();
        if (mem_result_id_o !== e.id || mem_result_rdata_o !== e.rdata || mem_result_err_o !== e.err) begin
          errors++;
          $display("FAIL result: got id=%0d rdata=0x%08h err=%0b expected id=%0d rdata=0x%08h err=%0b",
                   mem_result_id_o, mem_result_rdata_o, mem_result_err_o, e.id, e.rdata, e.err);
        end else begin
          $display("result id=%0d rdata=0x%08h err=%0b ok", e.id, e.rdata, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_txn(input vec_t v, input logic [3:0] id);
    exp_t e;
    chk("ready_before", mem_ready_o, 1'b1);
    mem_valid_i = 1'b1;
    mem_id_i    = id;
    mem_addr_i  = v.addr;
    mem_we_i    = v.we;
    mem_size_i  = v.size;
    mem_be_i    = v.be;
    mem_wdata_i = v.wdata;
    e.id    = id;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    exp_q.push_back(e);
    tick();
    // Scramble request inputs so the DUT must have registered them.
    mem_valid_i = 1'b0;
    mem_addr_i  = 32'hFFFF_FFFF;
    mem_we_i    = ~v.we;
    mem_be_i    = 4'b0101;
    mem_wdata_i = 32'hA5A5_A5A5;
    mem_size_i  = 2'd0;
    if (v.reject) begin
      chk("reject_no_req", data_req_o, 1'b0);
      chk("reject_valid_n1", mem_result_valid_o, 1'b1);
      tick();
      chk("reject_ready_n2", mem_ready_o, 1'b1);
      chk("reject_no_req2", data_req_o, 1'b0);
    end else begin
      for (int k = 0; k <= v.gnt_wait; k++) begin
        chk("req_high", data_req_o, 1'b1);
        chk("req_addr", data_addr_o, v.addr & 32'hFFFF_FFFC);
        chk("req_be", data_be_o, v.exp_be);
        chk("req_we", data_we_o, v.we);
        if (v.we) chk("req_wdata", data_wdata_o, v.wdata);
        chk("no_early_valid", mem_result_valid_o, 1'b0);
        data_gnt_i = (k == v.gnt_wait);
        tick();
      end
      data_gnt_i = 1'b0;
      chk("req_dropped", data_req_o, 1'b0);
      data_rvalid_i = 1'b1;
      data_rdata_i  = v.bus_rdata;
      data_err_i    = v.bus_err;
      tick();
      data_rvalid_i = 1'b0;
      data_rdata_i  = 32'h0;
      data_err_i    = 1'b0;
      chk("valid_latency", mem_result_valid_o, 1'b1);
      chk("ready_low_result", mem_ready_o, 1'b0);
      tick();
      chk("valid_one_cycle", mem_result_valid_o, 1'b0);
      chk("ready_after", mem_ready_o, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //           addr          we    size  be     wdata          bus_rdata      berr  gw rej   exp_be exp_rdata      exp_err
    vecs[0] = '{32'h0000_0100, 1'b0, 2'd2, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'h0000_0103, 1'b0, 2'd0, 4'h0, 32'h0,         32'hAB00_0000, 1'b0, 0, 1'b0, 4'h8, 32'h0000_00AB, 1'b0};
    vecs[2] = '{32'h0000_0200, 1'b1, 2'd2, 4'hF, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 3, 1'b0, 4'hF, 32'h0,         1'b0};
    vecs[3] = '{32'h0000_0300, 1'b0, 2'd2, 4'h0, 32'h0,         32'h55AA_55AA, 1'b1, 0, 1'b0, 4'hF, 32'h0,         1'b1};
    vecs[4] = '{32'h0000_0400, 1'b0, 2'd3, 4'h0, 32'h0,         32'h0,         1'b0, 0, 1'b1, 4'h0, 32'h0,         1'b1};
`ifdef XIF_MEM_MISALIGN_CHECK_EN
    vecs[5] = '{32'h0000_0101, 1'b0, 2'd1, 4'h0, 32'h0,         32'h1234_5678, 1'b0, 0, 1'b1, 4'h0, 32'h0,         1'b1};
`else
    vecs[5] = '{32'h0000_0101, 1'b0, 2'd1, 4'h0, 32'h0,         32'h1234_5678, 1'b0, 0, 1'b0, 4'h6, 32'h0000_3456, 1'b0};
`endif
    vecs[6] = '{32'h0000_0102, 1'b0, 2'd1, 4'h0, 32'h0,         32'hCAFE_BABE, 1'b0, 1, 1'b0, 4'hC, 32'h0000_CAFE, 1'b0};
    vecs[7] = '{32'h0000_0005, 1'b1, 2'd0, 4'h2, 32'h0000_AA00, 32'h7777_7777, 1'b0, 0, 1'b0, 4'h2, 32'h0,         1'b0};
    vecs[8] = '{32'h0000_0001, 1'b0, 2'd0, 4'h0, 32'h0,         32'h1122_3344, 1'b0, 2, 1'b0, 4'h2, 32'h0000_0033, 1'b0};

    rst_i = 1'b1;
    mem_valid_i = 1'b0; mem_id_i = 4'h0; mem_addr_i = 32'h0; mem_we_i = 1'b0;
    mem_size_i = 2'd0; mem_be_i = 4'h0; mem_wdata_i = 32'h0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0; data_err_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    chk("reset_ready", mem_ready_o, 1'b1);
    chk("reset_valid", mem_result_valid_o, 1'b0);
    chk("reset_req", data_req_o, 1'b0);
    chk("reset_rdata", mem_result_rdata_o, 32'h0);
    chk("reset_err", mem_result_err_o, 1'b0);
    chk("reset_id", mem_result_id_o, 4'h0);
    chk("reset_addr", data_addr_o, 32'h0);
    chk("reset_be", data_be_o, 4'h0);

    for (int i = 0; i < 9; i++) begin
      $display("txn %0d addr=0x%08h we=%0b size=%0d", i, vecs[i].addr, vecs[i].we, vecs[i].size);
      do_txn(vecs[i], 4'(i + 1));
    end

    // Stray response while idle must not produce a result.
    data_rvalid_i = 1'b1; data_rdata_i = 32'h9999_9999;
    tick();
    data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    chk("stray_no_valid", mem_result_valid_o, 1'b0);
    chk("stray_ready", mem_ready_o, 1'b1);

    // Reset during BUS_WAIT, then a late response.
    $display("txn reset-mid-transaction");
    mem_valid_i = 1'b1; mem_id_i = 4'hE; mem_addr_i = 32'h500; mem_we_i = 1'b0; mem_size_i = 2'd2;
    tick();
    mem_valid_i = 1'b0;
    chk("rst_seq_req", data_req_o, 1'b1);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    chk("rst_seq_wait", data_req_o, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_seq_ready", mem_ready_o, 1'b1);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1357_9BDF;
    tick();
    data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    chk("rst_seq_no_valid", mem_result_valid_o, 1'b0);
    chk("rst_seq_ready2", mem_ready_o, 1'b1);
    tick();
    chk("rst_seq_no_valid2", mem_result_valid_o, 1'b0);

    $display("txn fresh after reset");
    do_txn(vecs[0], 4'hD);

    tick();
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
